data_bus_port: RTL and testbench
================================

// Module: data_bus_port
// PURPOSE
//  Parametrised per-module port onto the shared tri-state crypto data bus (bus_data/bus_valid).
//  The control module (source_id == all ones) opens a transaction with a header word naming source and dest.
//  After a guard delay the named source drives its queued words, and participants receive them.
//  A global ack closes the transaction. One instance sits between each module and the bus.
//  Generalises the 8-bit/2-bit-ID bus port: widths, guard delay and TX buffering are parameters, with an explicit FSM.
// PARAMETERS
//  DATA_W    8  bus/payload width; must be >= 2+2*ID_W
//  ID_W      2  module ID width; CTRL_ID = {ID_W{1'b1}}
//  GRANT_DLY 3  guard cycles between header and data phase; >= 1
//  TX_DEPTH  4  TX FIFO depth, power of 2, >= 2
// PORTS
//  clk         in     1        clock
//  rst_n       in     1        asynchronous active-low reset
//  source_id   in     ID_W     this port's module ID (static)
//  send_valid  in     1        word on send_data offered to TX FIFO
//  send_data   in     DATA_W   word to send
//  send_ready  out    1        TX FIFO not full; write = send_valid && send_ready
//  ack         in     1        global end-of-transaction, synchronous, all ports see it
//  recv_valid  out    1        registered: recv_data valid this cycle
//  recv_data   out    DATA_W   received payload word
//  busy        out    1        FSM not IDLE
//  proto_err   out    1        sticky: bus_valid seen during GUARD
//  bus_data    inout  DATA_W   shared bus data, Z when not driving
//  bus_valid   inout  1        shared bus valid, Z when not driving (bus pull-down assumed 0)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, FIFO empty, send_ready=1, recv_valid=0, recv_data=0, busy=0, proto_err=0; bus released to Z at once.
//  Header word: src = bus_data[2+ID_W-1:2], dst = bus_data[2+2*ID_W-1:2+ID_W], bits[1:0] reserved/ignored.
//  FSM states: IDLE, GUARD, XFER.
//   IDLE: bus_valid==1 at posedge -> latch src/dst, cnt<=0 -> GUARD. Applies to every port, including the control port.
//   GUARD: cnt increments each cycle; when cnt==GRANT_DLY-1 -> XFER. is_src=(source_id==src), is_part=is_src|dst match|CTRL_ID.
//   XFER: stays until ack.
//   ack at posedge in any state -> IDLE and clears src/dst/cnt. ack beats a simultaneous header capture.
//  Drive (combinational from state): drive = !empty && ((IDLE && source_id==CTRL_ID) || (XFER && is_src)).
//   While drive is high: bus_data = FIFO head, bus_valid = 1; FIFO pops at the posedge. Otherwise both outputs are Z.
//   The control port sends exactly one header word per transaction; further control words wait for IDLE.
//  Receive: in XFER with is_part && !drive && bus_valid -> next cycle recv_valid=1, recv_data=bus_data (1-cycle latency).
//   Otherwise recv_valid=0 and recv_data holds its last value. The header is never delivered on recv.
//   A driving port never sees its own words on recv.
//  TX FIFO: TX_DEPTH words, ptrs wrap mod TX_DEPTH, extra MSB distinguishes full from empty.
//   Push and pop in the same cycle when full is allowed: count unchanged, send_ready stays 0 that cycle.
//   Words not sent at ack are retained and drive again only when a later header names this port as src.
//  proto_err: set when bus_valid==1 in GUARD; cleared only by reset. The FSM continues normally.
//  Non-participants in XFER ignore the bus and never drive it.
// TESTING
//  T1 reset: hold rst_n=0 -> send_ready=1, recv_valid=0, busy=0, bus_data/bus_valid Z; assert rst_n=0 mid-XFER -> bus Z same cycle.
//  T2 transfer (defaults): port3 queues 8'h24 (src=1,dst=2); port1 queues A5,5A.
//     -> header on bus at cycle 0; port1 drives A5 cycle 4 and 5A cycle 5.
//     -> port2 and port3 recv_valid with A5 cycle 5 and 5A cycle 6; port0 and port1 recv_valid stay 0.
//  T3 FIFO full: 4 writes with no header -> send_ready=0 after 4th, 5th write refused.
//     -> drive one word in XFER -> send_ready=1 next cycle; push+pop while full keeps count=4.
//  T4 ack mid-XFER: port1 has 3 words, ack after 1st driven -> all ports IDLE next cycle, bus Z, port1 FIFO count=2.
//     -> next header naming src=1 -> remaining 2 words delivered in order.
//  T5 guard violation: force bus_valid=1 in GUARD cycle 2 -> proto_err=1 and stays 1 after ack; XFER still entered on time.
//  T6 ack+header same edge: ack and bus_valid high together in IDLE -> stays IDLE, busy=0, no src latched.

Source files
------------

// File: rtl/data_bus_port.sv
// data_bus_port: one module's port onto the shared tri-state data bus with TX FIFO, guard delay and receive path
module data_bus_port #(
   parameter int DATA_W    = 8,
   parameter int ID_W      = 2,
   parameter int GRANT_DLY = 3,
   parameter int TX_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   source_id,
   input  logic              send_valid,
   input  logic [DATA_W-1:0] send_data,
   output logic              send_ready,
   input  logic              ack,
   output logic              recv_valid,
   output logic [DATA_W-1:0] recv_data,
   output logic              busy,
   output logic              proto_err,
   inout  wire  [DATA_W-1:0] bus_data,
   inout  wire               bus_valid
);
   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = (GRANT_DLY > 1) ? $clog2(GRANT_DLY) : 1;
   localparam logic [ID_W-1:0] CTRL_ID = '1;
   typedef enum logic [1:0] {IDLE, GUARD, XFER} state_t;
   state_t            state_q, state_d;
   logic [ID_W-1:0]   src_q, src_d, dst_q, dst_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [TX_DEPTH];
   logic [PW:0]       wr_q, rd_q;
   logic              recv_valid_q, recv_valid_d, perr_q, perr_d;
   logic [DATA_W-1:0] recv_data_q, recv_data_d;
   logic              empty, full, is_src, is_part, drive, push, bv;
   assign empty      = wr_q == rd_q;
   assign full       = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign is_src     = source_id == src_q;
   assign is_part    = is_src || source_id == dst_q || source_id == CTRL_ID;
   assign drive      = !empty && ((state_q == IDLE && source_id == CTRL_ID) || (state_q == XFER && is_src));
   // a full FIFO still takes a word when the head leaves in the same cycle, so the count holds
   assign push       = send_valid && (!full || drive);
   assign send_ready = !full;
   assign bv         = bus_valid == 1'b1;
   assign bus_data   = drive ? mem_q[rd_q[PW-1:0]] : {DATA_W{1'bz}};
   assign bus_valid  = drive ? 1'b1 : 1'bz;
   assign recv_valid = recv_valid_q;
   assign recv_data  = recv_data_q;
   assign busy       = state_q != IDLE;
   assign proto_err  = perr_q;
   // next state: ack wins over everything, a header opens the guard window, guard counts into XFER
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      if (ack) begin
         state_d = IDLE;
         src_d   = '0;
         dst_d   = '0;
         cnt_d   = '0;
      end else if (state_q == IDLE) begin
         if (bv) begin
            state_d = GUARD;
            src_d   = bus_data[2+:ID_W];
            dst_d   = bus_data[2+ID_W+:ID_W];
            cnt_d   = '0;
         end
      end else if (state_q == GUARD) begin
         if (cnt_q == CW'(GRANT_DLY - 1)) state_d = XFER;
         else cnt_d = cnt_q + 1'b1;
      end
   end
   // receive path and sticky guard-violation flag
   always_comb begin
      recv_valid_d = state_q == XFER && is_part && !drive && bv;
      recv_data_d  = recv_valid_d ? bus_data : recv_data_q;
      perr_d       = perr_q || (state_q == GUARD && bv);
   end
   // control and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         cnt_q        <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         recv_valid_q <= 1'b0;
         recv_data_q  <= '0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_q + (PW+1)'(push);
         rd_q         <= rd_q + (PW+1)'(drive);
         recv_valid_q <= recv_valid_d;
         recv_data_q  <= recv_data_d;
         perr_q       <= perr_d;
      end
   end
   // FIFO storage needs no reset; the pointers define which entries are live
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[PW-1:0]] <= send_data;
   end
endmodule

// File: tb/tb_data_bus_port.sv
// tb_data_bus_port: four ports on one bus, checked against a transaction-level bus model
module tb_data_bus_port;
   localparam int GD = 3;
   logic       clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
   logic       sv [4];
   logic [7:0] sd [4];
   logic       sr [4], rv [4], bz [4], pe [4];
   logic [7:0] rd [4];
   logic       tb_drv_v = 1'b0;
   logic [7:0] tb_drv_d = 8'h00;
   wire  [7:0] bus_data;
   wire        bus_valid;
   int         vecs = 0, errs = 0;
   int         age, m_src, m_dst, exp_drv;
   logic [7:0] mq [4][$];
   logic       m_rv [4];
   logic [7:0] m_rd [4];
   logic       m_perr, exp_bv;
   logic [7:0] exp_bd;

   pulldown (bus_valid);
   assign bus_valid = tb_drv_v ? 1'b1 : 1'bz;
   assign bus_data  = tb_drv_v ? tb_drv_d : 8'bz;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_port
      data_bus_port #(.DATA_W(8), .ID_W(2), .GRANT_DLY(GD), .TX_DEPTH(4)) u_port (
         .clk(clk), .rst_n(rst_n), .source_id(2'(g)),
         .send_valid(sv[g]), .send_data(sd[g]), .send_ready(sr[g]),
         .ack(ack), .recv_valid(rv[g]), .recv_data(rd[g]),
         .busy(bz[g]), .proto_err(pe[g]),
         .bus_data(bus_data), .bus_valid(bus_valid));
   end

   function automatic logic [7:0] hdr(int s, int d);
      return 8'((d << 4) | (s << 2));
   endfunction

   task automatic model_reset();
      age = 0; m_src = 0; m_dst = 0; m_perr = 1'b0;
      for (int p = 0; p < 4; p++) begin
         mq[p].delete(); m_rv[p] = 1'b0; m_rd[p] = 8'h00;
      end
   endtask

   // bus owner: control port while no transaction is open, named source once the guard has elapsed
   task automatic predict();
      exp_drv = -1;
      if (age == 0 && mq[3].size() > 0) exp_drv = 3;
      else if (age > GD && mq[m_src].size() > 0) exp_drv = m_src;
      exp_bv = exp_drv >= 0 || tb_drv_v;
      exp_bd = exp_drv >= 0 ? mq[exp_drv][0] : tb_drv_d;
   endtask

   task automatic tick();
      logic       nrv [4];
      logic [7:0] nrd [4];
      logic       acc [4];
      predict();
      for (int p = 0; p < 4; p++) begin
         nrv[p] = age > GD && (p == m_src || p == m_dst || p == 3) && p != exp_drv && exp_bv;
         nrd[p] = nrv[p] ? exp_bd : m_rd[p];
         acc[p] = sv[p] && (mq[p].size() < 4 || exp_drv == p);
      end
      if (exp_drv >= 0) void'(mq[exp_drv].pop_front());
      for (int p = 0; p < 4; p++) if (acc[p]) mq[p].push_back(sd[p]);
      if (age >= 1 && age <= GD && exp_bv) m_perr = 1'b1;
      if (ack) begin
         age = 0; m_src = 0; m_dst = 0;
      end else if (age == 0 && exp_bv) begin
         age = 1; m_src = int'(exp_bd[3:2]); m_dst = int'(exp_bd[5:4]);
      end else if (age >= 1 && age <= GD) age++;
      for (int p = 0; p < 4; p++) begin
         m_rv[p] = nrv[p]; m_rd[p] = nrd[p];
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) sv[p] = 1'b0;
      ack = 1'b0; tb_drv_v = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic push(int p, logic [7:0] d);
      sv[p] = 1'b1; sd[p] = d;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
         vecs += 5;
         if (sr[p] !== 1'b1) begin errs++; $display("FAIL reset_ready[%0d] got %b exp 1", p, sr[p]); end
         if (rv[p] !== 1'b0) begin errs++; $display("FAIL reset_rv[%0d] got %b exp 0", p, rv[p]); end
         if (rd[p] !== 8'h00) begin errs++; $display("FAIL reset_rd[%0d] got %h exp 00", p, rd[p]); end
         if (bz[p] !== 1'b0) begin errs++; $display("FAIL reset_busy[%0d] got %b exp 0", p, bz[p]); end
         if (pe[p] !== 1'b0) begin errs++; $display("FAIL reset_perr[%0d] got %b exp 0", p, pe[p]); end
      end
      vecs++;
      if (bus_valid !== 1'b0) begin errs++; $display("FAIL reset_bus_valid got %b exp 0", bus_valid); end
      model_reset();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_transfer();
      push(1, 8'hA5); push(1, 8'h5A); push(3, 8'h24);
      vecs += 2;
      if (bus_valid !== 1'b1 || bus_data !== 8'h24) begin errs++; $display("FAIL xfer_header got %b/%h exp 1/24", bus_valid, bus_data); end
      if (bz[0] !== 1'b0) begin errs++; $display("FAIL xfer_busy_c0 got %b exp 0", bz[0]); end
      tick();
      for (int c = 1; c <= 3; c++) begin
         vecs += 2;
         if (bus_valid !== 1'b0) begin errs++; $display("FAIL xfer_guard_bus c%0d got %b exp 0", c, bus_valid); end
         if (bz[2] !== 1'b1) begin errs++; $display("FAIL xfer_guard_busy c%0d got %b exp 1", c, bz[2]); end
         tick();
      end
      vecs += 2;
      if (bus_valid !== 1'b1 || bus_data !== 8'hA5) begin errs++; $display("FAIL xfer_c4_bus got %b/%h exp 1/a5", bus_valid, bus_data); end
      if (rv[2] !== 1'b0) begin errs++; $display("FAIL xfer_c4_rv2 got %b exp 0", rv[2]); end
      tick();
      vecs += 5;
      if (bus_valid !== 1'b1 || bus_data !== 8'h5A) begin errs++; $display("FAIL xfer_c5_bus got %b/%h exp 1/5a", bus_valid, bus_data); end
      if (rv[2] !== 1'b1 || rd[2] !== 8'hA5) begin errs++; $display("FAIL xfer_c5_p2 got %b/%h exp 1/a5", rv[2], rd[2]); end
      if (rv[3] !== 1'b1 || rd[3] !== 8'hA5) begin errs++; $display("FAIL xfer_c5_p3 got %b/%h exp 1/a5", rv[3], rd[3]); end
      if (rv[0] !== 1'b0) begin errs++; $display("FAIL xfer_c5_rv0 got %b exp 0", rv[0]); end
      if (rv[1] !== 1'b0) begin errs++; $display("FAIL xfer_c5_rv1 got %b exp 0", rv[1]); end
      tick();
      vecs += 4;
      if (rv[2] !== 1'b1 || rd[2] !== 8'h5A) begin errs++; $display("FAIL xfer_c6_p2 got %b/%h exp 1/5a", rv[2], rd[2]); end
      if (rv[3] !== 1'b1 || rd[3] !== 8'h5A) begin errs++; $display("FAIL xfer_c6_p3 got %b/%h exp 1/5a", rv[3], rd[3]); end
      if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin errs++; $display("FAIL xfer_c6_rv01 got %b%b exp 00", rv[0], rv[1]); end
      if (bus_valid !== 1'b0) begin errs++; $display("FAIL xfer_c6_bus got %b exp 0", bus_valid); end
      ack = 1'b1; tick();
      vecs++;
      if (bz[1] !== 1'b0) begin errs++; $display("FAIL xfer_ack_busy got %b exp 0", bz[1]); end
   endtask

   task automatic test_fifo_full();
      logic [7:0] w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] got [$];
      for (int i = 0; i < 4; i++) push(0, w[i]);
      vecs++;
      if (sr[0] !== 1'b0) begin errs++; $display("FAIL full_ready got %b exp 0", sr[0]); end
      push(0, 8'hEE);
      vecs++;
      if (sr[0] !== 1'b0) begin errs++; $display("FAIL full_refuse_ready got %b exp 0", sr[0]); end
      push(3, hdr(0, 1));
      repeat (GD + 1) tick();
      for (int c = 0; c < 9; c++) begin
         if (c == 0) begin
            sv[0] = 1'b1; sd[0] = w[4];
            vecs += 2;
            if (sr[0] !== 1'b0) begin errs++; $display("FAIL full_pushpop_ready got %b exp 0", sr[0]); end
            if (bus_data !== w[0]) begin errs++; $display("FAIL full_first_word got %h exp %h", bus_data, w[0]); end
         end
         if (c == 1) begin
            vecs++;
            if (sr[0] !== 1'b0) begin errs++; $display("FAIL full_count_held got %b exp 0", sr[0]); end
         end
         if (c == 2) begin
            vecs++;
            if (sr[0] !== 1'b1) begin errs++; $display("FAIL full_ready_back got %b exp 1", sr[0]); end
         end
         if (rv[1]) got.push_back(rd[1]);
         tick();
      end
      vecs++;
      if (got.size() != 5) begin errs++; $display("FAIL full_recv_count got %0d exp 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         vecs++;
         if (got[i] !== w[i]) begin errs++; $display("FAIL full_recv[%0d] got %h exp %h", i, got[i], w[i]); end
      end
      ack = 1'b1; tick();
   endtask

   task automatic test_ack_mid();
      logic [7:0] got [$];
      push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3); push(3, hdr(1, 0));
      repeat (GD + 1) tick();
      vecs++;
      if (bus_data !== 8'hB1) begin errs++; $display("FAIL ackmid_first got %h exp b1", bus_data); end
      ack = 1'b1; tick();
      vecs++;
      if (bus_valid !== 1'b0) begin errs++; $display("FAIL ackmid_bus got %b exp 0", bus_valid); end
      for (int p = 0; p < 4; p++) begin
         vecs++;
         if (bz[p] !== 1'b0) begin errs++; $display("FAIL ackmid_busy[%0d] got %b exp 0", p, bz[p]); end
      end
      push(3, hdr(1, 2));
      for (int c = 0; c < 10; c++) begin
         if (rv[2]) got.push_back(rd[2]);
         tick();
      end
      vecs++;
      if (got.size() != 2) begin errs++; $display("FAIL ackmid_count got %0d exp 2", got.size()); end
      else begin
         vecs++;
         if (got[0] !== 8'hB2 || got[1] !== 8'hB3) begin errs++; $display("FAIL ackmid_order got %h,%h exp b2,b3", got[0], got[1]); end
      end
      ack = 1'b1; tick();
   endtask

   task automatic test_ack_header();
      push(3, hdr(1, 2));
      ack = 1'b1; tick();
      for (int c = 0; c < 2; c++) begin
         vecs += 2;
         if (bz[2] !== 1'b0) begin errs++; $display("FAIL ackhdr_busy c%0d got %b exp 0", c, bz[2]); end
         if (bus_valid !== 1'b0) begin errs++; $display("FAIL ackhdr_bus c%0d got %b exp 0", c, bus_valid); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 4; p++) begin
            sv[p] = (p < 3) ? ($urandom % 4 == 0) : ($urandom % 12 == 0);
            sd[p] = 8'($urandom);
         end
         ack = $urandom % 10 == 0;
         #1;
         predict();
         vecs++;
         if (bus_valid !== exp_bv) begin errs++; $display("FAIL rand_bus_valid cyc %0d got %b exp %b", c, bus_valid, exp_bv); end
         if (exp_bv) begin
            vecs++;
            if (bus_data !== exp_bd) begin errs++; $display("FAIL rand_bus_data cyc %0d got %h exp %h", c, bus_data, exp_bd); end
         end
         for (int p = 0; p < 4; p++) begin
            vecs += 5;
            if (sr[p] !== (mq[p].size() < 4)) begin errs++; $display("FAIL rand_ready[%0d] cyc %0d got %b exp %b", p, c, sr[p], mq[p].size() < 4); end
            if (rv[p] !== m_rv[p]) begin errs++; $display("FAIL rand_rv[%0d] cyc %0d got %b exp %b", p, c, rv[p], m_rv[p]); end
            if (rd[p] !== m_rd[p]) begin errs++; $display("FAIL rand_rd[%0d] cyc %0d got %h exp %h", p, c, rd[p], m_rd[p]); end
            if (bz[p] !== (age != 0)) begin errs++; $display("FAIL rand_busy[%0d] cyc %0d got %b exp %b", p, c, bz[p], age != 0); end
            if (pe[p] !== m_perr) begin errs++; $display("FAIL rand_perr[%0d] cyc %0d got %b exp %b", p, c, pe[p], m_perr); end
         end
         tick();
      end
      ack = 1'b1; tick();
      for (int p = 0; p < 4; p++) while (mq[p].size() > 0) void'(mq[p].pop_front());
      rst_n = 1'b0; #1; model_reset();
      @(negedge clk); rst_n = 1'b1; #1;
   endtask

   task automatic test_guard_violation();
      push(2, 8'hC7); push(3, hdr(2, 0));
      tick(); tick();
      tb_drv_v = 1'b1; tb_drv_d = 8'h3C;
      tick();
      for (int p = 0; p < 4; p++) begin
         vecs++;
         if (pe[p] !== 1'b1) begin errs++; $display("FAIL guard_perr[%0d] got %b exp 1", p, pe[p]); end
      end
      tick();
      vecs++;
      if (bus_valid !== 1'b1 || bus_data !== 8'hC7) begin errs++; $display("FAIL guard_xfer_on_time got %b/%h exp 1/c7", bus_valid, bus_data); end
      ack = 1'b1; tick();
      tick();
      for (int p = 0; p < 4; p++) begin
         vecs++;
         if (pe[p] !== 1'b1) begin errs++; $display("FAIL guard_perr_sticky[%0d] got %b exp 1", p, pe[p]); end
      end
   endtask

   task automatic test_async_reset();
      push(1, 8'hD1); push(1, 8'hD2); push(3, hdr(1, 0));
      repeat (GD + 1) tick();
      vecs++;
      if (bus_valid !== 1'b1) begin errs++; $display("FAIL areset_pre_drive got %b exp 1", bus_valid); end
      rst_n = 1'b0;
      #1;
      vecs++;
      if (bus_valid !== 1'b0) begin errs++; $display("FAIL areset_bus got %b exp 0", bus_valid); end
      for (int p = 0; p < 4; p++) begin
         vecs += 3;
         if (bz[p] !== 1'b0) begin errs++; $display("FAIL areset_busy[%0d] got %b exp 0", p, bz[p]); end
         if (sr[p] !== 1'b1) begin errs++; $display("FAIL areset_ready[%0d] got %b exp 1", p, sr[p]); end
         if (pe[p] !== 1'b0) begin errs++; $display("FAIL areset_perr[%0d] got %b exp 0", p, pe[p]); end
      end
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      for (int p = 0; p < 4; p++) begin
         sv[p] = 1'b0; sd[p] = 8'h00;
      end
      model_reset();
      test_reset();
      test_transfer();
      test_fifo_full();
      test_ack_mid();
      test_ack_header();
      test_random();
      test_guard_violation();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
